rr_lock_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 32 +++
 rtl/arb_pick.sv | 44 ++++
 rtl/rr_lock_arbiter.sv | 158 +++++++++++++++
 tb/tb_rr_lock_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared constants, FSM state type and helpers for the
//               rr_lock_arbiter block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

   localparam int ARB_MODE_FIXED = 0;   // lowest index wins
   localparam int ARB_MODE_RR    = 1;   // round-robin from pointer

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } arb_state_t;

   // Binary index of a one-hot vector (up to 32 requesters). ORing the
   // indices keeps the result free of any priority chain.
   function automatic int onehot_to_idx(input logic [31:0] onehot);
      int idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (onehot[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// ============================================================================
// Module      : arb_pick
// Description : Combinational winner picker. Rotates the request vector so
//               the pointer position lands at bit 0, isolates the lowest set
//               bit, and rotates the result back. Fixed-priority mode simply
//               forces the rotation amount to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_pick
   import arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int MODE = ARB_MODE_RR,
   parameter int IW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic          found
);

   logic [IW-1:0]  eff_ptr;
   logic [2*N-1:0] dbl_req;
   logic [2*N-1:0] dbl_win;
   logic [N-1:0]   rot_req;
   logic [N-1:0]   rot_win;

   // Rotate-and-mask pick: the halves of each double-width word are ORed
   // because the half that received shifted-in zeros is a subset of the other.
   always_comb begin
      eff_ptr = (MODE == ARB_MODE_RR) ? ptr : '0;
      dbl_req = {req, req} >> eff_ptr;
      rot_req = dbl_req[N-1:0] | dbl_req[2*N-1:N];
      rot_win = rot_req & (~rot_req + N'(1));
      dbl_win = {rot_win, rot_win} << eff_ptr;
      winner  = dbl_win[2*N-1:N] | dbl_win[N-1:0];
      found   = |req;
   end

endmodule

`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
// ============================================================================
// Module      : rr_lock_arbiter
// Description : N-way arbiter with registered one-hot grant, fixed-priority
//               or round-robin policy, and grant locking until the owner
//               releases (explicitly, by dropping its request, or by timeout).
//               Optional feature macro: ARB_TIMEOUT_EN (bounded hold time,
//               adds the timeout output and a hold counter).
//               The release input is called owner_release because "release"
//               is a reserved SystemVerilog keyword.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_lock_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MODE     = ARB_MODE_RR,
   parameter int MAX_HOLD = 16,
   parameter int IW       = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          owner_release,
   output logic [N-1:0]  grant,
   output logic          grant_valid,
   output logic [IW-1:0] grant_id
`ifdef ARB_TIMEOUT_EN
   ,
   output logic          timeout
`endif
);

   arb_state_t    state;
   arb_state_t    state_nx;
   logic [N-1:0]  grant_nx;
   logic [N-1:0]  winner;
   logic [IW-1:0] id_nx;
   logic [IW-1:0] ptr;
   logic [IW-1:0] ptr_nx;
   logic [IW-1:0] ptr_inc;
   logic [IW-1:0] pick_ptr;
   logic          found;
   logic          owner_req;
   logic          hold_end;
   logic          own_end;

   // Explicit wrap so the pointer never reaches N for non-power-of-two N.
   assign ptr_inc   = (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);

   // While owned the only pick that matters is the hand-over pick, which must
   // already see the pointer that ownership end will install.
   assign pick_ptr  = (state == ST_OWNED) ? ptr_inc : ptr;
   assign owner_req = |(req & grant);

   arb_pick #(
      .N    (N),
      .MODE (MODE),
      .IW   (IW)
   ) u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .winner (winner),
      .found  (found)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD + 1);

   logic [CW-1:0] hold_cnt;
   logic [CW-1:0] hold_cnt_nx;
   logic          timeout_nx;

   // Counter value MAX_HOLD-1 marks the MAX_HOLD-th owned cycle.
   assign hold_end = (hold_cnt == CW'(MAX_HOLD - 1));
`else
   assign hold_end = 1'b0;
`endif

   assign own_end = (state == ST_OWNED) && (owner_release || !owner_req || hold_end);

   // Next-state, grant hand-over and pointer update.
   always_comb begin
      state_nx = state;
      grant_nx = grant;
      id_nx    = grant_id;
      ptr_nx   = ptr;
      case (state)
         ST_IDLE: begin
            if (found) begin
               state_nx = ST_OWNED;
               grant_nx = winner;
               id_nx    = IW'(onehot_to_idx(32'(winner)));
            end
         end
         ST_OWNED: begin
            if (own_end) begin
               ptr_nx = ptr_inc;
               if (found) begin
                  grant_nx = winner;
                  id_nx    = IW'(onehot_to_idx(32'(winner)));
               end else begin
                  state_nx = ST_IDLE;
                  grant_nx = '0;
               end
            end
         end
         default: begin
            state_nx = ST_IDLE;
            grant_nx = '0;
         end
      endcase
   end

   // State, grant and pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         grant    <= '0;
         grant_id <= '0;
         ptr      <= '0;
      end else begin
         state    <= state_nx;
         grant    <= grant_nx;
         grant_id <= id_nx;
         ptr      <= ptr_nx;
      end
   end

   assign grant_valid = |grant;

`ifdef ARB_TIMEOUT_EN
   // Hold counter restarts on every new grant; timeout only when the limit,
   // not the owner, ended the ownership.
   always_comb begin
      hold_cnt_nx = '0;
      if ((state == ST_OWNED) && !own_end) begin
         hold_cnt_nx = hold_cnt + CW'(1);
      end
      timeout_nx = own_end && hold_end && owner_req && !owner_release;
   end

   // Hold counter and timeout pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         hold_cnt <= hold_cnt_nx;
         timeout  <= timeout_nx;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
// ============================================================================
// Module      : tb_rr_lock_arbiter
// Description : Self-checking bench for rr_lock_arbiter: table-driven
//               vectors for fixed-priority and round-robin, plus hand-written
//               sequences for N=3 wrap, asynchronous reset and the optional
//               ARB_TIMEOUT_EN hold limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_lock_arbiter;

   typedef struct packed {
      logic [3:0] req;
      logic       rel;
      logic [3:0] grant;
      logic       valid;
      logic [1:0] id;
   } vec_t;

   logic clk;
   logic rst_n;

   int checks;
   int errors;

   // fixed priority, N=4
   logic [3:0] fp_req;
   logic       fp_rel;
   logic [3:0] fp_grant;
   logic       fp_valid;
   logic [1:0] fp_id;
   // round-robin, N=4
   logic [3:0] rr_req;
   logic       rr_rel;
   logic [3:0] rr_grant;
   logic       rr_valid;
   logic [1:0] rr_id;
   // round-robin, N=3
   logic [2:0] r3_req;
   logic       r3_rel;
   logic [2:0] r3_grant;
   logic       r3_valid;
   logic [1:0] r3_id;
   // round-robin, N=4, short hold limit
   logic [3:0] to_req;
   logic       to_rel;
   logic [3:0] to_grant;
   logic       to_valid;
   logic [1:0] to_id;
`ifdef ARB_TIMEOUT_EN
   logic       fp_tmo;
   logic       rr_tmo;
   logic       r3_tmo;
   logic       to_tmo;
`endif

   rr_lock_arbiter #(.N(4), .MODE(0), .MAX_HOLD(16)) u_fp (
      .clk(clk), .rst_n(rst_n), .req(fp_req), .owner_release(fp_rel),
      .grant(fp_grant), .grant_valid(fp_valid), .grant_id(fp_id)
`ifdef ARB_TIMEOUT_EN
      , .timeout(fp_tmo)
`endif
   );

   rr_lock_arbiter #(.N(4), .MODE(1), .MAX_HOLD(16)) u_rr (
      .clk(clk), .rst_n(rst_n), .req(rr_req), .owner_release(rr_rel),
      .grant(rr_grant), .grant_valid(rr_valid), .grant_id(rr_id)
`ifdef ARB_TIMEOUT_EN
      , .timeout(rr_tmo)
`endif
   );

   rr_lock_arbiter #(.N(3), .MODE(1), .MAX_HOLD(16)) u_r3 (
      .clk(clk), .rst_n(rst_n), .req(r3_req), .owner_release(r3_rel),
      .grant(r3_grant), .grant_valid(r3_valid), .grant_id(r3_id)
`ifdef ARB_TIMEOUT_EN
      , .timeout(r3_tmo)
`endif
   );

   rr_lock_arbiter #(.N(4), .MODE(1), .MAX_HOLD(4)) u_to (
      .clk(clk), .rst_n(rst_n), .req(to_req), .owner_release(to_rel),
      .grant(to_grant), .grant_valid(to_valid), .grant_id(to_id)
`ifdef ARB_TIMEOUT_EN
      , .timeout(to_tmo)
`endif
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the stimulus ever stalls
   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t fp_vec [13];
   vec_t rr_vec [13];

   initial begin
      logic [3:0] exp_g;
      logic       exp_t;

      checks = 0;
      errors = 0;

      //                req      rel   grant    valid id
      fp_vec[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
      fp_vec[1]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1};
      fp_vec[2]  = '{4'b1011, 1'b0, 4'b0010, 1'b1, 2'd1}; // locked
      fp_vec[3]  = '{4'b1011, 1'b0, 4'b0010, 1'b1, 2'd1};
      fp_vec[4]  = '{4'b1011, 1'b1, 4'b0001, 1'b1, 2'd0}; // hand-over, no bubble
      fp_vec[5]  = '{4'b1001, 1'b0, 4'b0001, 1'b1, 2'd0};
      fp_vec[6]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3}; // implicit release
      fp_vec[7]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3}; // idle, id held
      fp_vec[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3}; // release in idle
      fp_vec[9]  = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};
      fp_vec[10] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1}; // fixed: same winner
      fp_vec[11] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
      fp_vec[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2};

      rr_vec[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0};
      rr_vec[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      rr_vec[2]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1};
      rr_vec[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
      rr_vec[4]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2};
      rr_vec[5]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
      rr_vec[6]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3};
      rr_vec[7]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0}; // wrap
      rr_vec[8]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0}; // sole requester re-wins
      rr_vec[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0}; // ptr now 1
      rr_vec[10] = '{4'b0101, 1'b0, 4'b0100, 1'b1, 2'd2};
      rr_vec[11] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0}; // ptr 3 wraps to bit 0
      rr_vec[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0}; // ptr now 1

      fp_req = '0; fp_rel = 1'b0;
      rr_req = '0; rr_rel = 1'b0;
      r3_req = '0; r3_rel = 1'b0;
      to_req = '0; to_rel = 1'b0;
      rst_n  = 1'b0;

      // Reset values
      tick();
      check("rst fp grant", 32'(fp_grant), 32'h0);
      check("rst fp valid", 32'(fp_valid), 32'h0);
      check("rst rr id",    32'(rr_id),    32'h0);
      check("rst r3 grant", 32'(r3_grant), 32'h0);
`ifdef ARB_TIMEOUT_EN
      check("rst timeout",  32'(to_tmo),   32'h0);
`endif
      rst_n = 1'b1;
      tick();

      // Fixed-priority table
      for (int i = 0; i < 13; i++) begin
         fp_req = fp_vec[i].req;
         fp_rel = fp_vec[i].rel;
         tick();
         check($sformatf("fp[%0d] grant", i), 32'(fp_grant), 32'(fp_vec[i].grant));
         check($sformatf("fp[%0d] valid", i), 32'(fp_valid), 32'(fp_vec[i].valid));
         check($sformatf("fp[%0d] id", i),    32'(fp_id),    32'(fp_vec[i].id));
      end
      fp_req = '0; fp_rel = 1'b0;

      // Round-robin table
      for (int i = 0; i < 13; i++) begin
         rr_req = rr_vec[i].req;
         rr_rel = rr_vec[i].rel;
         tick();
         check($sformatf("rr[%0d] grant", i), 32'(rr_grant), 32'(rr_vec[i].grant));
         check($sformatf("rr[%0d] valid", i), 32'(rr_valid), 32'(rr_vec[i].valid));
         check($sformatf("rr[%0d] id", i),    32'(rr_id),    32'(rr_vec[i].id));
      end
      rr_req = '0; rr_rel = 1'b0;

      // N=3: owner 2 releases, pointer wraps to 0
      r3_req = 3'b100; r3_rel = 1'b0;
      tick();
      check("r3 first grant", 32'(r3_grant), 32'h4);
      check("r3 first id",    32'(r3_id),    32'h2);
      r3_req = 3'b111;
      tick();
      check("r3 locked", 32'(r3_grant), 32'h4);
      r3_req = 3'b011; r3_rel = 1'b1;
      tick();
      check("r3 wrap grant", 32'(r3_grant), 32'h1);
      check("r3 wrap id",    32'(r3_id),    32'h0);
      tick();
      check("r3 next grant", 32'(r3_grant), 32'h2);
      r3_req = 3'b000; r3_rel = 1'b0;
      tick();
      check("r3 idle valid", 32'(r3_valid), 32'h0);

`ifdef ARB_TIMEOUT_EN
      // Hold limit of 4: grant moves every 4 cycles with a timeout pulse
      to_req = 4'b0011; to_rel = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp_g = (k <= 4 || k >= 9) ? 4'b0001 : 4'b0010;
         exp_t = (k == 5 || k == 9);
         check($sformatf("tmo[%0d] grant", k), 32'(to_grant), 32'(exp_g));
         check($sformatf("tmo[%0d] pulse", k), 32'(to_tmo),   32'(exp_t));
      end
      // Genuine release in the limit cycle: no timeout
      to_rel = 1'b1;
      tick();
      check("tmo rel grant", 32'(to_grant), 32'h2);
      check("tmo rel pulse", 32'(to_tmo),   32'h0);
      to_rel = 1'b0; to_req = '0;
      tick();
      check("tmo idle grant", 32'(to_grant), 32'h0);
`else
      exp_g = '0;
      exp_t = 1'b0;
      tick();
      check("to idle grant", 32'(to_grant), 32'(exp_g));
      check("to idle valid", 32'(to_valid), 32'(exp_t));
`endif

      // Drive ptr to 3, then reset asynchronously while owned
      rr_req = 4'b0100; rr_rel = 1'b0;
      tick();
      check("pre-rst grant", 32'(rr_grant), 32'h4);
      rr_rel = 1'b1;
      tick();
      check("pre-rst regrant", 32'(rr_grant), 32'h4);
      rr_rel = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check("async rst grant", 32'(rr_grant), 32'h0);
      check("async rst valid", 32'(rr_valid), 32'h0);
      check("async rst id",    32'(rr_id),    32'h0);
      #2;
      rst_n = 1'b1;
      rr_req = 4'b1001;
      tick();
      check("post-rst grant", 32'(rr_grant), 32'h1);
      check("post-rst id",    32'(rr_id),    32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
